// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the MU0 shared-memory arbiter: two requester ports (A = CPU
// datapath, B = UART debug/loader), the debug lock pair, and the memory side.
// The slave modport is the arbiter's view; master is the requester/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // port A
  logic              a_req;
  logic              a_rnw;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rvalid;
  // port B
  logic              b_req;
  logic              b_rnw;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;
  logic              b_rvalid;
  // debug lock
  logic              b_lock;
  logic              b_locked;
  // memory side
  logic              mem_en;
  logic              mem_rnw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  a_req, a_rnw, a_addr, a_wdata,
    output a_ack, a_rdata, a_rvalid,
    input  b_req, b_rnw, b_addr, b_wdata,
    output b_ack, b_rdata, b_rvalid,
    input  b_lock,
    output b_locked,
    output mem_en, mem_rnw, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output a_req, a_rnw, a_addr, a_wdata,
    input  a_ack, a_rdata, a_rvalid,
    output b_req, b_rnw, b_addr, b_wdata,
    input  b_ack, b_rdata, b_rvalid,
    output b_lock,
    input  b_locked,
    input  mem_en, mem_rnw, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the MU0 shared program/data memory.
// Grants at most one command per cycle, round-robin on a tie, honours a
// debug bus lock held by port B, and routes read data back to the issuing
// port through a tag pipeline matched to the memory read latency.
//
// Lock FSM states:
//   state   | meaning
//   LK_FREE | no lock; A and B arbitrate normally
//   LK_HELD | B owns the bus; A is never granted
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic {
    LK_FREE = 1'b0,
    LK_HELD = 1'b1
  } lock_state_t;

  lock_state_t lock_state, lock_next;

  logic              a_elig, b_elig;
  logic              grant_a, grant_b;
  logic              last_grant_b;

  logic              a_ack_q, b_ack_q;
  logic              mem_en_q, mem_rnw_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // One tag stage per cycle of memory latency: valid read + owner (1 = B).
  logic [RD_LATENCY-1:0] tag_vld;
  logic [RD_LATENCY-1:0] tag_own;
  logic                  tag_out_vld;
  logic                  tag_out_own;

  logic              a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  // Eligibility and round-robin winner; a port acked this cycle is skipped so
  // a held request is not issued twice, and the lock shuts A out entirely.
  always_comb begin
    a_elig  = bus.a_req & ~a_ack_q & (lock_state == LK_FREE);
    b_elig  = bus.b_req & ~b_ack_q;
    grant_a = a_elig & (~b_elig | last_grant_b);
    grant_b = b_elig & ~grant_a;
  end

  // Lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state <= LK_FREE;
    end else begin
      lock_state <= lock_next;
    end
  end

  // Lock next-state: taken only on a B grant with b_lock high, dropped on the
  // first edge that sees b_lock low.
  always_comb begin
    lock_next = lock_state;
    case (lock_state)
      LK_FREE: if (grant_b && bus.b_lock) lock_next = LK_HELD;
      LK_HELD: if (!bus.b_lock)           lock_next = LK_FREE;
      default: lock_next = LK_FREE;
    endcase
  end

  // Round-robin pointer; B after reset so A takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_b <= 1'b1;
    end else if (grant_a) begin
      last_grant_b <= 1'b0;
    end else if (grant_b) begin
      last_grant_b <= 1'b1;
    end
  end

  // Command issue: register the winner onto the memory bus and ack it in the
  // same cycle; with no winner the command fields hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rnw_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      a_ack_q  <= grant_a;
      b_ack_q  <= grant_b;
      mem_en_q <= grant_a | grant_b;
      if (grant_a) begin
        mem_rnw_q   <= bus.a_rnw;
        mem_addr_q  <= bus.a_addr;
        mem_wdata_q <= bus.a_wdata;
      end else if (grant_b) begin
        mem_rnw_q   <= bus.b_rnw;
        mem_addr_q  <= bus.b_addr;
        mem_wdata_q <= bus.b_wdata;
      end
    end
  end

  // Tag pipeline: entry is loaded the cycle after the command strobe, so the
  // last stage lines up with the cycle in which mem_rdata is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_own <= '0;
    end else begin
      tag_vld[0] <= mem_en_q & mem_rnw_q;
      tag_own[0] <= b_ack_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_own[i] <= tag_own[i-1];
      end
    end
  end

  assign tag_out_vld = tag_vld[RD_LATENCY-1];
  assign tag_out_own = tag_own[RD_LATENCY-1];

  // Read return: capture memory data into the owner's holding register and
  // pulse its rvalid; the other port's data stays untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= tag_out_vld & ~tag_out_own;
      b_rvalid_q <= tag_out_vld &  tag_out_own;
      if (tag_out_vld && !tag_out_own) a_rdata_q <= bus.mem_rdata;
      if (tag_out_vld &&  tag_out_own) b_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.a_ack     = a_ack_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.a_rvalid  = a_rvalid_q;
  assign bus.b_rvalid  = b_rvalid_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.b_locked  = (lock_state == LK_HELD);
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_rnw   = mem_rnw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table on a latency-1 instance
// plus hand sequences for pipelined reads (latency 3) and reset mid-read.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(3)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // Memory model: fixed contents, read data appears RD_LATENCY cycles after
  // the address is on the bus.
  function automatic logic [15:0] rom(input logic [15:0] addr);
    case (addr)
      16'h0010: rom = 16'h1234;
      16'h0020: rom = 16'hBEEF;
      16'h0001: rom = 16'h1111;
      16'h0002: rom = 16'h2222;
      16'h0003: rom = 16'h3333;
      default:  rom = ~addr;
    endcase
  endfunction

  logic [15:0] p1;
  logic [15:0] p2 [3];
  always @(posedge clk) begin
    p1    <= rom(bus1.mem_addr);
    p2[0] <= rom(bus2.mem_addr);
    p2[1] <= p2[0];
    p2[2] <= p2[1];
  end
  assign bus1.mem_rdata = p1;
  assign bus2.mem_rdata = p2[2];

  typedef struct packed {
    logic ar; logic arnw; logic [15:0] aaddr; logic [15:0] awd;
    logic br; logic brnw; logic [15:0] baddr; logic [15:0] bwd;
    logic blk;
  } in_t;

  typedef struct packed {
    logic aack; logic back; logic men; logic mrnw;
    logic [15:0] maddr; logic [15:0] mwd; logic blkd;
    logic arv; logic [15:0] ard; logic brv; logic [15:0] brd;
  } out_t;

  typedef struct { in_t i; out_t o; } vec_t;

  localparam int NV = 31;
  vec_t tbl [NV];

  int passed = 0;
  int total  = 0;

  function automatic in_t ii(input int ar, arnw, aaddr, awd, br, brnw, baddr, bwd, blk);
    in_t r;
    r.ar = ar[0]; r.arnw = arnw[0]; r.aaddr = aaddr[15:0]; r.awd = awd[15:0];
    r.br = br[0]; r.brnw = brnw[0]; r.baddr = baddr[15:0]; r.bwd = bwd[15:0];
    r.blk = blk[0];
    return r;
  endfunction

  function automatic out_t oo(input int aack, back, men, mrnw, maddr, mwd, blkd, arv, ard, brv, brd);
    out_t r;
    r.aack = aack[0]; r.back = back[0]; r.men = men[0]; r.mrnw = mrnw[0];
    r.maddr = maddr[15:0]; r.mwd = mwd[15:0]; r.blkd = blkd[0];
    r.arv = arv[0]; r.ard = ard[15:0]; r.brv = brv[0]; r.brd = brd[15:0];
    return r;
  endfunction

  task automatic drive1(input in_t v);
    bus1.a_req = v.ar; bus1.a_rnw = v.arnw; bus1.a_addr = v.aaddr; bus1.a_wdata = v.awd;
    bus1.b_req = v.br; bus1.b_rnw = v.brnw; bus1.b_addr = v.baddr; bus1.b_wdata = v.bwd;
    bus1.b_lock = v.blk;
  endtask

  function automatic out_t sample1();
    out_t r;
    r.aack = bus1.a_ack; r.back = bus1.b_ack; r.men = bus1.mem_en; r.mrnw = bus1.mem_rnw;
    r.maddr = bus1.mem_addr; r.mwd = bus1.mem_wdata; r.blkd = bus1.b_locked;
    r.arv = bus1.a_rvalid; r.ard = bus1.a_rdata; r.brv = bus1.b_rvalid; r.brd = bus1.b_rdata;
    return r;
  endfunction

  function automatic out_t sample2();
    out_t r;
    r.aack = bus2.a_ack; r.back = bus2.b_ack; r.men = bus2.mem_en; r.mrnw = bus2.mem_rnw;
    r.maddr = bus2.mem_addr; r.mwd = bus2.mem_wdata; r.blkd = bus2.b_locked;
    r.arv = bus2.a_rvalid; r.ard = bus2.a_rdata; r.brv = bus2.b_rvalid; r.brd = bus2.b_rdata;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s[%0d]: got %h required %h", nm, idx, got, exp);
    end else begin
      passed++;
    end
  endtask

  initial begin
    in_t  idle, ca;
    out_t z;
    logic [35:0] exp2 [8];

    idle = ii(0,0,0,0, 0,0,0,0, 0);
    ca   = ii(1,0,'h0101,'hA001, 1,0,'h0201,'hB001, 0);
    z    = '0;

    // single A read, then single B read
    tbl[0]  = '{ii(1,1,'h0010,0, 0,0,0,0, 0), oo(1,0,1,1,'h0010,0,0, 0,0,0,0)};
    tbl[1]  = '{idle, oo(0,0,0,1,'h0010,0,0, 0,0,0,0)};
    tbl[2]  = '{idle, oo(0,0,0,1,'h0010,0,0, 1,'h1234,0,0)};
    tbl[3]  = '{idle, oo(0,0,0,1,'h0010,0,0, 0,'h1234,0,0)};
    tbl[4]  = '{ii(0,0,0,0, 1,1,'h0020,0, 0), oo(0,1,1,1,'h0020,0,0, 0,'h1234,0,0)};
    tbl[5]  = '{idle, oo(0,0,0,1,'h0020,0,0, 0,'h1234,0,0)};
    tbl[6]  = '{idle, oo(0,0,0,1,'h0020,0,0, 0,'h1234,1,'hBEEF)};
    tbl[7]  = '{idle, oo(0,0,0,1,'h0020,0,0, 0,'h1234,0,'hBEEF)};
    // contention: 4 writes each, strict alternation starting with A
    for (int n = 8; n <= 14; n++) begin
      if (n % 2 == 0) tbl[n] = '{ca, oo(1,0,1,0,'h0101,'hA001,0, 0,'h1234,0,'hBEEF)};
      else            tbl[n] = '{ca, oo(0,1,1,0,'h0201,'hB001,0, 0,'h1234,0,'hBEEF)};
    end
    tbl[15] = '{ii(0,0,0,0, 1,0,'h0201,'hB001, 0), oo(0,1,1,0,'h0201,'hB001,0, 0,'h1234,0,'hBEEF)};
    tbl[16] = '{idle, oo(0,0,0,0,'h0201,'hB001,0, 0,'h1234,0,'hBEEF)};
    // lock: B takes the bus, A held off through four B writes
    tbl[17] = '{ii(0,0,0,0, 1,0,'h0005,'h00AA, 1), oo(0,1,1,0,'h0005,'h00AA,1, 0,'h1234,0,'hBEEF)};
    tbl[18] = '{ii(1,0,'h0300,'hC000, 1,0,'h0006,'h00AB, 1), oo(0,0,0,0,'h0005,'h00AA,1, 0,'h1234,0,'hBEEF)};
    tbl[19] = '{ii(1,0,'h0300,'hC000, 1,0,'h0006,'h00AB, 1), oo(0,1,1,0,'h0006,'h00AB,1, 0,'h1234,0,'hBEEF)};
    tbl[20] = '{ii(1,0,'h0300,'hC000, 1,0,'h0007,'h00AC, 1), oo(0,0,0,0,'h0006,'h00AB,1, 0,'h1234,0,'hBEEF)};
    tbl[21] = '{ii(1,0,'h0300,'hC000, 1,0,'h0007,'h00AC, 1), oo(0,1,1,0,'h0007,'h00AC,1, 0,'h1234,0,'hBEEF)};
    tbl[22] = '{ii(1,0,'h0300,'hC000, 1,0,'h0008,'h00AD, 1), oo(0,0,0,0,'h0007,'h00AC,1, 0,'h1234,0,'hBEEF)};
    tbl[23] = '{ii(1,0,'h0300,'hC000, 1,0,'h0008,'h00AD, 1), oo(0,1,1,0,'h0008,'h00AD,1, 0,'h1234,0,'hBEEF)};
    // b_lock drops: A still blocked on that edge, granted on the next
    tbl[24] = '{ii(1,0,'h0300,'hC000, 0,0,0,0, 0), oo(0,0,0,0,'h0008,'h00AD,0, 0,'h1234,0,'hBEEF)};
    tbl[25] = '{ii(1,0,'h0300,'hC000, 0,0,0,0, 0), oo(1,0,1,0,'h0300,'hC000,0, 0,'h1234,0,'hBEEF)};
    // b_lock without a B grant does not lock
    tbl[26] = '{ii(0,0,0,0, 0,0,0,0, 1), oo(0,0,0,0,'h0300,'hC000,0, 0,'h1234,0,'hBEEF)};
    tbl[27] = '{idle, oo(0,0,0,0,'h0300,'hC000,0, 0,'h1234,0,'hBEEF)};
    // A write to the top address: no read return
    tbl[28] = '{ii(1,0,'hFFFF,'hCAFE, 0,0,0,0, 0), oo(1,0,1,0,'hFFFF,'hCAFE,0, 0,'h1234,0,'hBEEF)};
    tbl[29] = '{idle, oo(0,0,0,0,'hFFFF,'hCAFE,0, 0,'h1234,0,'hBEEF)};
    tbl[30] = '{idle, oo(0,0,0,0,'hFFFF,'hCAFE,0, 0,'h1234,0,'hBEEF)};

    // {a_ack, b_ack, a_rvalid, b_rvalid, a_rdata, b_rdata} for latency-3 reads
    exp2[0] = {4'b1000, 16'h0000, 16'h0000};
    exp2[1] = {4'b0100, 16'h0000, 16'h0000};
    exp2[2] = {4'b1000, 16'h0000, 16'h0000};
    exp2[3] = {4'b0000, 16'h0000, 16'h0000};
    exp2[4] = {4'b0010, 16'h1111, 16'h0000};
    exp2[5] = {4'b0001, 16'h1111, 16'h2222};
    exp2[6] = {4'b0010, 16'h3333, 16'h2222};
    exp2[7] = {4'b0000, 16'h3333, 16'h2222};

    drive1(idle);
    bus2.a_req = 0; bus2.a_rnw = 0; bus2.a_addr = 0; bus2.a_wdata = 0;
    bus2.b_req = 0; bus2.b_rnw = 0; bus2.b_addr = 0; bus2.b_wdata = 0;
    bus2.b_lock = 0;

    repeat (3) @(negedge clk);
    chk("reset_state_l1", 0, 128'(sample1()), 128'(z));
    chk("reset_state_l3", 0, 128'(sample2()), 128'(z));
    rst = 1'b0;

    for (int n = 0; n < NV; n++) begin
      drive1(tbl[n].i);
      @(negedge clk);
      chk("vec", n, 128'(sample1()), 128'(tbl[n].o));
    end

    // pipelined reads A,B,A on the latency-3 instance
    bus2.a_req = 1; bus2.a_rnw = 1; bus2.a_addr = 16'h0001;
    bus2.b_req = 1; bus2.b_rnw = 1; bus2.b_addr = 16'h0002;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("pipe_rd", c, 128'({bus2.a_ack, bus2.b_ack, bus2.a_rvalid, bus2.b_rvalid, bus2.a_rdata, bus2.b_rdata}), 128'(exp2[c]));
      if (c == 0) bus2.a_addr = 16'h0003;
      if (c == 1) bus2.b_req = 0;
      if (c == 2) bus2.a_req = 0;
    end

    // reset one cycle after a read ack on the latency-1 instance
    drive1(ii(1,1,'h0010,0, 0,0,0,0, 0));
    @(negedge clk);
    chk("rst_pre_ack", 0, 128'({bus1.a_ack, bus1.b_ack}), 128'(2'b10));
    drive1(idle);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_zero", 0, 128'(sample1()), 128'(z));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_rvalid", c, 128'(sample1()), 128'(z));
    end
    drive1(ii(1,0,'h0400,'h4444, 1,0,'h0500,'h5555, 0));
    @(negedge clk);
    chk("rst_tie_to_a", 0, 128'({bus1.a_ack, bus1.b_ack, bus1.mem_addr}), 128'({2'b10, 16'h0400}));
    drive1(idle);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
